// File: rtl/fns_pkg.sv
// Shared definitions for the Fibonacci-numeral-system (FNS) encoder.
//   fib(n)         : Fibonacci number with F(1) = F(2) = 1 (constant function).
//   fns_max(cw)    : largest value a cw-bit Zeckendorf codeword can hold, F(cw+2)-1.
//   bit_width(v)   : number of bits needed to hold the unsigned value v (min 1).
//   fns_state_t    : encoder FSM states.
package fns_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } fns_state_t;

    function automatic int fib(input int n);
        int a;
        int b;
        int t;
        a = 1;
        b = 1;
        for (int k = 3; k <= n; k++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return (n <= 0) ? 0 : b;
    endfunction

    function automatic int fns_max(input int code_w);
        return fib(code_w + 2) - 1;
    endfunction

    function automatic int bit_width(input int v);
        int w;
        w = 1;
        while ((v >> w) != 0) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/fib_step_down.sv
// One greedy Zeckendorf step with the Fibonacci weights stepped downward.
//   w_hi_i, w_lo_i : current weight F(k) and the one below it, F(k-1).
//   rem_i          : remainder still to be encoded.
//   bit_o          : 1 when the current weight is taken.
//   rem_o          : remainder after the optional subtraction.
//   w_hi_o, w_lo_o : weights for the next step, F(k-1) and F(k-2).
// Purely combinational, all arithmetic unsigned at WT_W bits.
module fib_step_down #(
    parameter int WT_W = 9
) (
    input  logic [WT_W-1:0] w_hi_i,
    input  logic [WT_W-1:0] w_lo_i,
    input  logic [WT_W-1:0] rem_i,
    output logic            bit_o,
    output logic [WT_W-1:0] rem_o,
    output logic [WT_W-1:0] w_hi_o,
    output logic [WT_W-1:0] w_lo_o
);

    always_comb begin
        bit_o  = (rem_i >= w_hi_i);
        rem_o  = bit_o ? (rem_i - w_hi_i) : rem_i;
        w_hi_o = w_lo_i;
        // F(k-2) = F(k) - F(k-1); wraps harmlessly on the last step.
        w_lo_o = w_hi_i - w_lo_i;
    end

endmodule

// File: rtl/fns_encoder_seq.sv
// Sequential FNS encoder: one Zeckendorf code bit per clock, MSB first.
//   clk, rst        : clock and asynchronous active-high reset.
//   in_valid/ready  : input handshake; in_data/in_bypass sampled on accept.
//   out_valid/ready : output handshake; out_code/out_err held while stalled.
//   out_code        : codeword, or zero-extended raw data when out_err = 1.
//   out_err         : word was passed through (forced bypass or > MAX_VAL).
//   busy            : encoder is not idle.
module fns_encoder_seq
    import fns_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CODE_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_bypass,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_code,
    output logic              out_err,
    output logic              busy
);

    localparam int FHI_W = bit_width(fib(CODE_W + 1));
    localparam int WT_W  = ((DATA_W > FHI_W) ? DATA_W : FHI_W) + 1;
    localparam int IDX_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;

    localparam logic [WT_W-1:0]  MAX_VAL   = WT_W'(fns_max(CODE_W));
    localparam logic [WT_W-1:0]  W_HI_INIT = WT_W'(fib(CODE_W + 1));
    localparam logic [WT_W-1:0]  W_LO_INIT = WT_W'(fib(CODE_W));
    localparam logic [IDX_W-1:0] IDX_INIT  = IDX_W'(CODE_W - 1);

    generate
        if (CODE_W < DATA_W || DATA_W < 2) begin : g_bad_params
            $error("fns_encoder_seq: need DATA_W >= 2 and CODE_W >= DATA_W");
        end
    endgenerate

    fns_state_t        state_q;
    logic [DATA_W-1:0] rem_q;
    logic [WT_W-1:0]   w_hi_q;
    logic [WT_W-1:0]   w_lo_q;
    logic [IDX_W-1:0]  idx_q;
    logic [CODE_W-1:0] code_q;
    logic              err_q;
    logic              valid_q;
    logic              ready_q;
    logic              busy_q;

    logic              step_bit;
    logic [WT_W-1:0]   step_rem;
    logic [WT_W-1:0]   step_w_hi;
    logic [WT_W-1:0]   step_w_lo;

    fib_step_down #(
        .WT_W (WT_W)
    ) u_step (
        .w_hi_i (w_hi_q),
        .w_lo_i (w_lo_q),
        .rem_i  (WT_W'(rem_q)),
        .bit_o  (step_bit),
        .rem_o  (step_rem),
        .w_hi_o (step_w_hi),
        .w_lo_o (step_w_lo)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            w_hi_q  <= '0;
            w_lo_q  <= '0;
            idx_q   <= '0;
            code_q  <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid && ready_q) begin
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (in_bypass || (WT_W'(in_data) > MAX_VAL)) begin
                            // Raw pass-through, ready on the very next cycle.
                            code_q  <= CODE_W'(in_data);
                            err_q   <= 1'b1;
                            valid_q <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            rem_q   <= in_data;
                            w_hi_q  <= W_HI_INIT;
                            w_lo_q  <= W_LO_INIT;
                            idx_q   <= IDX_INIT;
                            code_q  <= '0;
                            err_q   <= 1'b0;
                            state_q <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    code_q[idx_q] <= step_bit;
                    // Remainder never exceeds the input, so it fits DATA_W.
                    rem_q  <= step_rem[DATA_W-1:0];
                    w_hi_q <= step_w_hi;
                    w_lo_q <= step_w_lo;
                    if (idx_q == '0) begin
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Greedy selection must consume the whole value by the last bit.
    a_rem_zero_at_exit: assert property (
        @(posedge clk) disable iff (rst)
        (state_q == SHIFT && idx_q == '0) |-> (step_rem == '0)
    );

    assign in_ready  = ready_q;
    assign out_valid = valid_q;
    assign out_code  = code_q;
    assign out_err   = err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_fns_encoder_seq.sv
// Bench for fns_encoder_seq: two instances sharing the handshake inputs
// (DATA_W=8 and DATA_W=9, both CODE_W=12) plus a standalone fib_step_down.
module tb_fns_encoder_seq;

    localparam int CODE_W  = 12;
    localparam int LAT_ENC = CODE_W + 1;
    localparam int LAT_BYP = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [8:0]  in_data = '0;
    logic        in_bypass = 1'b0;
    logic        out_ready = 1'b1;

    logic        in_ready_a, out_valid_a, out_err_a, busy_a;
    logic [11:0] out_code_a;
    logic        in_ready_b, out_valid_b, out_err_b, busy_b;
    logic [11:0] out_code_b;

    logic [8:0]  t_w_hi, t_w_lo, t_rem;
    logic        t_bit;
    logic [8:0]  t_rem_o, t_w_hi_o, t_w_lo_o;

    int n_vec = 0;
    int n_err = 0;
    int fibv [0:20];

    always #5 clk = ~clk;

    fns_encoder_seq #(.DATA_W(8), .CODE_W(CODE_W)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data[7:0]), .in_bypass(in_bypass), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_code(out_code_a), .out_err(out_err_a), .busy(busy_a)
    );

    fns_encoder_seq #(.DATA_W(9), .CODE_W(CODE_W)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .in_bypass(in_bypass), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_code(out_code_b), .out_err(out_err_b), .busy(busy_b)
    );

    fib_step_down #(.WT_W(9)) u_step (
        .w_hi_i(t_w_hi), .w_lo_i(t_w_lo), .rem_i(t_rem),
        .bit_o(t_bit), .rem_o(t_rem_o), .w_hi_o(t_w_hi_o), .w_lo_o(t_w_lo_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected result straight from the Zeckendorf definition.
    function automatic void expect_word(input int v, input bit byp, output logic [11:0] code,
                                        output logic err, output int lat);
        int r;
        code = '0;
        if (byp || v > fibv[CODE_W + 2] - 1) begin
            code = 12'(v);
            err  = 1'b1;
            lat  = LAT_BYP;
        end else begin
            r = v;
            for (int i = CODE_W - 1; i >= 0; i--) begin
                if (r >= fibv[i + 2]) begin
                    code[i] = 1'b1;
                    r -= fibv[i + 2];
                end
            end
            err = 1'b0;
            lat = LAT_ENC;
        end
    endfunction

    function automatic int decode(input logic [11:0] code);
        int s = 0;
        for (int i = 0; i < CODE_W; i++) if (code[i]) s += fibv[i + 2];
        return s;
    endfunction

    // One word through both encoders; stall = cycles out_ready is held low once valid.
    task automatic xfer(input logic [8:0] d, input logic byp, input int stall);
        logic [11:0] ea, eb, ga, gb;
        logic        era, erb, gea, geb;
        int          la, lb, oa, ob;
        expect_word(int'(d[7:0]), byp, ea, era, la);
        expect_word(int'(d), byp, eb, erb, lb);
        check("ready_a_idle", in_ready_a, 1);
        check("ready_b_idle", in_ready_b, 1);
        out_ready = (stall == 0);
        in_valid  = 1'b1;
        in_data   = d;
        in_bypass = byp;
        oa = 0; ob = 0; ga = '0; gb = '0; gea = 1'b0; geb = 1'b0;
        for (int cyc = 1; cyc <= 40 && (oa == 0 || ob == 0); cyc++) begin
            @(posedge clk); #1;
            if (cyc == 1) begin
                in_valid  = 1'b0;
                in_data   = 9'($urandom);
                in_bypass = 1'($urandom);
            end
            if (out_valid_a && oa == 0) begin oa = cyc; ga = out_code_a; gea = out_err_a; end
            if (out_valid_b && ob == 0) begin ob = cyc; gb = out_code_b; geb = out_err_b; end
        end
        check("lat_a", oa, la);
        check("lat_b", ob, lb);
        check("code_a", ga, ea);
        check("err_a", gea, era);
        check("code_b", gb, eb);
        check("err_b", geb, erb);
        if (!era) begin
            check("adjacent_a", ga & (ga >> 1), 0);
            check("decode_a", decode(ga), int'(d[7:0]));
        end
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            check("stall_valid_a", out_valid_a, 1);
            check("stall_code_a", out_code_a, ea);
            check("stall_err_a", out_err_a, era);
            check("stall_ready_a", in_ready_a, 0);
            check("stall_valid_b", out_valid_b, 1);
            check("stall_code_b", out_code_b, eb);
            check("stall_err_b", out_err_b, erb);
            check("stall_ready_b", in_ready_b, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("post_valid_a", out_valid_a, 0);
        check("post_busy_a", busy_a, 0);
        check("post_valid_b", out_valid_b, 0);
        check("post_busy_b", busy_b, 0);
        $display("xfer d=0x%03h byp=%0d stall=%0d: a=0x%03h err=%0d lat=%0d | b=0x%03h err=%0d lat=%0d",
                 d, byp, stall, ga, gea, oa, gb, geb, ob);
    endtask

    initial begin : main
        int perm [256];
        int k, t;
        bit quiet;

        fibv[0] = 0;
        fibv[1] = 1;
        for (int i = 2; i <= 20; i++) fibv[i] = fibv[i - 1] + fibv[i - 2];

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready_a", in_ready_a, 1);
        check("rst_valid_a", out_valid_a, 0);
        check("rst_code_a", out_code_a, 0);
        check("rst_err_a", out_err_a, 0);
        check("rst_busy_a", busy_a, 0);
        check("rst_ready_b", in_ready_b, 1);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // Directed words.
        xfer(9'd100, 1'b0, 0);
        xfer(9'd255, 1'b0, 0);
        xfer(9'd0, 1'b0, 0);
        xfer(9'd376, 1'b0, 0);
        xfer(9'd377, 1'b0, 0);
        xfer(9'h05A, 1'b1, 0);
        xfer(9'd100, 1'b0, 10);
        xfer(9'd255, 1'b0, 0);

        // Every 8-bit value in random order, random high bit for the 9-bit encoder.
        for (int i = 0; i < 256; i++) perm[i] = i;
        for (int i = 255; i > 0; i--) begin
            k = int'($urandom_range(i, 0));
            t = perm[i]; perm[i] = perm[k]; perm[k] = t;
        end
        for (int i = 0; i < 256; i++)
            xfer({1'($urandom), 8'(perm[i])}, 1'b0, int'($urandom_range(3, 0)));

        // Random forced bypasses.
        for (int i = 0; i < 20; i++)
            xfer(9'($urandom), 1'b1, int'($urandom_range(2, 0)));

        // Step stage on its own.
        for (int i = 0; i < 20; i++) begin
            k = int'($urandom_range(13, 3));
            t = int'($urandom_range(fibv[k + 1] - 1, 0));
            t_w_hi = 9'(fibv[k]);
            t_w_lo = 9'(fibv[k - 1]);
            t_rem  = 9'(t);
            #1;
            check("step_bit", t_bit, (t >= fibv[k]) ? 1 : 0);
            check("step_rem", t_rem_o, (t >= fibv[k]) ? t - fibv[k] : t);
            check("step_w_hi", t_w_hi_o, fibv[k - 1]);
            check("step_w_lo", t_w_lo_o, fibv[k - 2]);
        end

        // Asynchronous reset in the middle of an encode (idx = 5).
        in_valid = 1'b1;
        in_data  = 9'd100;
        in_bypass = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("arst_ready_a", in_ready_a, 1);
        check("arst_code_a", out_code_a, 0);
        check("arst_valid_a", out_valid_a, 0);
        check("arst_err_a", out_err_a, 0);
        check("arst_busy_a", busy_a, 0);
        check("arst_ready_b", in_ready_b, 1);
        check("arst_busy_b", busy_b, 0);
        @(negedge clk) rst = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid_a || out_valid_b || busy_a || busy_b) quiet = 1'b0;
        end
        check("arst_no_emit", quiet, 1);
        xfer(9'd100, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
